// File: rtl/systolic_conv_engine_if.sv
// Control, load-stream and result-stream signals of the systolic convolution engine.
// The master side drives jobs and data; the slave side is the engine.
interface systolic_conv_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              start;
  logic              cfg_signed;
  logic              cfg_relu;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_signed, cfg_relu, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, cfg_signed, cfg_relu, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/systolic_conv_engine.sv
// Valid-mode 2D correlation of an NxN tile with a KxK filter on a KxK weight-stationary
// PE grid, with stream load, signed/unsigned arithmetic, ReLU, saturation and a back-pressured output.
module systolic_conv_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int N      = 4,
  parameter int ACC_W  = 2*DATA_W+4,
  parameter int OUT_W  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst,
  systolic_conv_engine_if.slave bus
);
  localparam int M     = N-K+1;
  localparam int MM    = M*M;
  localparam int KK    = K*K;
  localparam int NN    = N*N;
  localparam int TOT   = KK+NN;
  localparam int LD_W  = $clog2(TOT);
  localparam int CMP_W = $clog2(MM+K);
  localparam int OIX_W = (MM > 1) ? $clog2(MM) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [LD_W-1:0]    ld_cnt_r;
  logic [CMP_W-1:0]   cmp_cnt_r;
  logic [OIX_W-1:0]   oidx_r;
  logic               cfg_signed_r;
  logic               cfg_relu_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [OUT_W-1:0]   out_data_r;
  logic               out_last_r;
  logic               busy_r;
  logic               done_r;
  logic [DATA_W-1:0]  filt_r [KK];
  logic [DATA_W-1:0]  pix_r  [NN];
  logic [OUT_W-1:0]   res_r  [MM];
  logic [DATA_W-1:0]  x_feed_s [K][K];
  logic [ACC_W-1:0]   psum_s   [K][K];
  logic [ACC_W-1:0]   sum_s;
  logic [OUT_W-1:0]   pp_s;

  // Operands are widened by one bit so one signed multiplier serves both modes.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic sgn);
    logic signed [DATA_W:0]     ae;
    logic signed [DATA_W:0]     be;
    logic signed [2*DATA_W+1:0] p;
    ae = $signed({sgn & a[DATA_W-1], a});
    be = $signed({sgn & b[DATA_W-1], b});
    p  = ae * be;
    return ACC_W'(p);
  endfunction

  function automatic logic [OUT_W-1:0] post_proc(input logic [ACC_W-1:0] acc,
                                                 input logic sgn,
                                                 input logic relu);
    logic signed [ACC_W-1:0] sv;
    logic signed [ACC_W-1:0] hi;
    logic [OUT_W-1:0]        res;
    sv  = $signed(acc);
    res = acc[OUT_W-1:0];
    if (sgn) begin
      if (relu && sv[ACC_W-1]) sv = {ACC_W{1'b0}};
      hi = sv >>> (OUT_W-1);
      if (hi == {ACC_W{1'b0}} || hi == {ACC_W{1'b1}}) res = sv[OUT_W-1:0];
      else if (sv[ACC_W-1])                           res = {1'b1, {(OUT_W-1){1'b0}}};
      else                                            res = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      if ((acc >> OUT_W) != {ACC_W{1'b0}}) res = {OUT_W{1'b1}};
      else                                 res = acc[OUT_W-1:0];
    end
    return res;
  endfunction

  // Skewed pixel feed: PE row i works on window (cmp_cnt - i), zero outside the job.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      automatic int p_v = int'(cmp_cnt_r) - i;
      for (int j = 0; j < K; j++) x_feed_s[i][j] = {DATA_W{1'b0}};
      if (p_v >= 0 && p_v < MM) begin
        for (int j = 0; j < K; j++)
          x_feed_s[i][j] = pix_r[(p_v / M + i) * N + (p_v % M) + j];
      end else begin
        for (int j = 0; j < K; j++) x_feed_s[i][j] = {DATA_W{1'b0}};
      end
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      logic [ACC_W-1:0] psum_in_s;
      logic [ACC_W-1:0] psum_r;
      if (gi == 0) begin : g_top
        assign psum_in_s = {ACC_W{1'b0}};
      end else begin : g_mid
        assign psum_in_s = psum_s[gi-1][gj];
      end
      assign psum_s[gi][gj] = psum_r;
      // PE: stationary tap times skewed pixel, added to the partial sum from above.
      always_ff @(posedge clk_in) begin
        psum_r <= psum_in_s + mul_ext(filt_r[gi*K+gj], x_feed_s[gi][gj], cfg_signed_r);
      end
    end
  end

  // Column outputs of the bottom PE row form one complete window result.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int j = 0; j < K; j++) sum_s = sum_s + psum_s[K-1][j];
    pp_s = post_proc(sum_s, cfg_signed_r, cfg_relu_r);
  end

  // Sequencing FSM with load, result buffering and registered stream outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r      <= S_IDLE;
      ld_cnt_r     <= {LD_W{1'b0}};
      cmp_cnt_r    <= {CMP_W{1'b0}};
      oidx_r       <= {OIX_W{1'b0}};
      cfg_signed_r <= 1'b0;
      cfg_relu_r   <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {OUT_W{1'b0}};
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            cfg_signed_r <= bus.cfg_signed;
            cfg_relu_r   <= bus.cfg_relu;
            ld_cnt_r     <= {LD_W{1'b0}};
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid && in_ready_r) begin
            if (int'(ld_cnt_r) < KK) filt_r[int'(ld_cnt_r)]      <= bus.in_data;
            else                     pix_r[int'(ld_cnt_r) - KK]  <= bus.in_data;
            if (int'(ld_cnt_r) == TOT-1) begin
              in_ready_r <= 1'b0;
              cmp_cnt_r  <= {CMP_W{1'b0}};
              state_r    <= S_COMPUTE;
            end else begin
              ld_cnt_r <= ld_cnt_r + LD_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (int'(cmp_cnt_r) >= K) res_r[int'(cmp_cnt_r) - K] <= pp_s;
          if (int'(cmp_cnt_r) == MM+K-1) begin
            out_valid_r <= 1'b1;
            out_data_r  <= (MM == 1) ? pp_s : res_r[0];
            out_last_r  <= (MM == 1);
            oidx_r      <= {OIX_W{1'b0}};
            state_r     <= S_OUTPUT;
          end else begin
            cmp_cnt_r <= cmp_cnt_r + CMP_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_valid_r && bus.out_ready) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= S_IDLE;
            end else begin
              oidx_r     <= oidx_r + OIX_W'(1);
              out_data_r <= res_r[int'(oidx_r) + 1];
              out_last_r <= (int'(oidx_r) + 1 == MM-1);
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_systolic_conv_engine.sv
// Directed, table-driven bench for systolic_conv_engine at N=4, K=3, 8-bit data and output.
module tb_systolic_conv_engine;
  localparam int DW = 8;
  localparam int KK = 9;
  localparam int NN = 16;
  localparam int MM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_conv_engine_if #(.DATA_W(DW), .OUT_W(8)) dut_if ();

  systolic_conv_engine #(
    .DATA_W(DW), .K(3), .N(4), .ACC_W(2*DW+4), .OUT_W(8)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (dut_if)
  );

  typedef struct {
    string      name;
    logic [7:0] f [KK];
    logic [7:0] x [NN];
    bit         sgn;
    bit         relu;
    logic [7:0] exp_v [MM];
  } vec_t;

  vec_t  tbl [6];
  int    n_cmp = 0;
  int    n_err = 0;
  string cur_job = "reset_state";

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s/%s: got %0d, required %0d", cur_job, nm, act, req);
    end
  endtask

  task automatic load_beats(input int idx, input int count, input bit gap, input bit noisy);
    for (int b = 0; b < count; b++) begin
      if (gap && (b == 3 || b == 12)) begin
        dut_if.in_valid = 1'b0;
        tick();
        tick();
        check("in_ready_in_gap", {31'd0, dut_if.in_ready}, 32'd1);
      end
      dut_if.in_valid = 1'b1;
      dut_if.in_data  = (b < KK) ? tbl[idx].f[b] : tbl[idx].x[b-KK];
      dut_if.start    = noisy;
      tick();
    end
    dut_if.in_valid = 1'b0;
    dut_if.start    = 1'b0;
  endtask

  task automatic run_job(input int idx, input bit bp, input bit gap, input bit noisy);
    int lat;
    cur_job           = tbl[idx].name;
    dut_if.start      = 1'b1;
    dut_if.cfg_signed = tbl[idx].sgn;
    dut_if.cfg_relu   = tbl[idx].relu;
    tick();
    dut_if.start      = 1'b0;
    dut_if.cfg_signed = 1'b0;
    dut_if.cfg_relu   = 1'b0;
    check("busy_after_start",     {31'd0, dut_if.busy},     32'd1);
    check("in_ready_after_start", {31'd0, dut_if.in_ready}, 32'd1);
    check("done_low",             {31'd0, dut_if.done},     32'd0);
    load_beats(idx, KK+NN, gap, noisy);
    check("in_ready_drop", {31'd0, dut_if.in_ready}, 32'd0);
    lat = 1;
    while (dut_if.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, 32'd8);
    for (int k = 0; k < MM; k++) begin
      check("out_data", {24'd0, dut_if.out_data}, {24'd0, tbl[idx].exp_v[k]});
      check("out_last", {31'd0, dut_if.out_last}, (k == MM-1) ? 32'd1 : 32'd0);
      if (bp && k == 1) begin
        dut_if.out_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_data",  {24'd0, dut_if.out_data},  {24'd0, tbl[idx].exp_v[1]});
          check("stall_valid", {31'd0, dut_if.out_valid}, 32'd1);
        end
        dut_if.out_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", {31'd0, dut_if.done},      32'd1);
    check("busy_end",   {31'd0, dut_if.busy},      32'd0);
    check("valid_end",  {31'd0, dut_if.out_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < KK; t++) tbl[i].f[t] = 8'd0;
      for (int t = 0; t < NN; t++) tbl[i].x[t] = 8'd0;
      for (int t = 0; t < MM; t++) tbl[i].exp_v[t] = 8'd0;
      tbl[i].sgn  = 1'b0;
      tbl[i].relu = 1'b0;
    end
    tbl[0].name = "identity";
    tbl[0].f[4] = 8'd1;
    for (int t = 0; t < NN; t++) tbl[0].x[t] = 8'(t);
    tbl[0].exp_v[0] = 8'd5;  tbl[0].exp_v[1] = 8'd6;
    tbl[0].exp_v[2] = 8'd9;  tbl[0].exp_v[3] = 8'd10;
    tbl[1].name = "all_ones";
    for (int t = 0; t < KK; t++) tbl[1].f[t] = 8'd1;
    for (int t = 0; t < NN; t++) tbl[1].x[t] = 8'(t);
    tbl[1].exp_v[0] = 8'd45; tbl[1].exp_v[1] = 8'd54;
    tbl[1].exp_v[2] = 8'd81; tbl[1].exp_v[3] = 8'd90;
    tbl[2].name = "unsigned_sat";
    for (int t = 0; t < KK; t++) tbl[2].f[t] = 8'd255;
    for (int t = 0; t < NN; t++) tbl[2].x[t] = 8'd255;
    for (int t = 0; t < MM; t++) tbl[2].exp_v[t] = 8'd255;
    tbl[3].name = "signed_relu_off";
    tbl[3].sgn = 1'b1;
    tbl[3].f[0] = 8'hFF;
    tbl[3].x[0] = 8'd5;
    tbl[3].exp_v[0] = 8'hFB;
    tbl[4].name = "signed_relu_on";
    tbl[4].sgn = 1'b1;
    tbl[4].relu = 1'b1;
    tbl[4].f[0] = 8'hFF;
    tbl[4].x[0] = 8'd5;
    tbl[5].name = "signed_sat";
    tbl[5].sgn = 1'b1;
    tbl[5].f[4] = 8'h80;
    tbl[5].x[5] = 8'h80;
    tbl[5].exp_v[0] = 8'h7F;

    rst               = 1'b1;
    dut_if.start      = 1'b0;
    dut_if.cfg_signed = 1'b0;
    dut_if.cfg_relu   = 1'b0;
    dut_if.in_valid   = 1'b0;
    dut_if.in_data    = 8'd0;
    dut_if.out_ready  = 1'b1;
    tick();
    tick();
    check("in_ready",  {31'd0, dut_if.in_ready},  32'd0);
    check("out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    check("out_data",  {24'd0, dut_if.out_data},  32'd0);
    check("out_last",  {31'd0, dut_if.out_last},  32'd0);
    check("busy",      {31'd0, dut_if.busy},      32'd0);
    check("done",      {31'd0, dut_if.done},      32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_job(i, (i == 1), (i == 2), (i == 2));

    // Abort a load after 7 beats, then confirm a clean job follows.
    cur_job      = "mid_load_reset";
    dut_if.start = 1'b1;
    tick();
    dut_if.start = 1'b0;
    load_beats(0, 7, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy",      {31'd0, dut_if.busy},      32'd0);
    check("in_ready",  {31'd0, dut_if.in_ready},  32'd0);
    check("out_valid", {31'd0, dut_if.out_valid}, 32'd0);
    check("done",      {31'd0, dut_if.done},      32'd0);
    tick();
    run_job(0, 1'b0, 1'b0, 1'b0);
    tick();
    cur_job = "idle_after";
    check("done_cleared", {31'd0, dut_if.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
